bit_deserializer: RTL and testbench

Serial-to-parallel frame receiver that consumes the registered single-bit stream produced by the gate-level D flip-flop stage (its `q` output). It detects a start bit, shifts in `WIDTH` data bits LSB-first, checks a stop bit, and presents the assembled word on a valid/ready handshake through a one-entry holding register. It also flags framing errors and overruns, so the downstream logic sees whole words instead of raw bits.

---
 rtl/bit_deserializer_if.sv | 21 ++
 rtl/bit_deserializer.sv | 120 ++++++++++++
 tb/tb_bit_deserializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bit_deserializer_if.sv
// Received-word handshake bundle for bit_deserializer.
// Master presents rx_data/rx_valid; slave returns rx_ready.
interface bit_deserializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/bit_deserializer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, stop bit.
// Words leave through a one-entry holding register on a valid/ready link.
module bit_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sdata,
    bit_deserializer_if.master  rx,
    output logic                frame_err,
    output logic                overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             good_stop;
    logic             drain;
    logic             commit;

    // State register; reset lands in ARM so a low line cannot fake a start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and shift/count datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_ARM: begin
                if (sdata) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!sdata) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_d            = shift_q >> 1;
                shift_d[WIDTH-1]   = sdata;
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                state_d = sdata ? ST_IDLE : ST_ARM;
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // Output logic: commit/overrun/frame error decisions and holding register.
    always_comb begin
        good_stop   = (state_q == ST_STOP) && sdata;
        drain       = rx_valid_q && rx.rx_ready;
        commit      = good_stop && (!rx_valid_q || drain);
        frame_err_d = (state_q == ST_STOP) && !sdata;
        overrun_d   = good_stop && rx_valid_q && !rx.rx_ready;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        if (commit) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end else if (drain) begin
            rx_valid_d = 1'b0;
        end
    end

    // Datapath and output registers; reset drops any partial word silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.rx_data  = rx_data_q;
    assign rx.rx_valid = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer, WIDTH=8.
// Drives bits on the falling edge and samples 1 time unit after the rising edge.
module tb_bit_deserializer;

    logic clk;
    logic reset_n;
    logic sdata;
    logic frame_err;
    logic overrun;
    int   vectors;
    int   fails;

    bit_deserializer_if #(.WIDTH(8)) rx_if ();

    bit_deserializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sdata     (sdata),
        .rx        (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_cyc(input logic b);
        @(negedge clk);
        sdata = b;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_body(input logic [7:0] d);
        bit_cyc(1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_cyc(d[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        frame_body(d);
        bit_cyc(stop);
    endtask

    initial begin
        vectors         = 0;
        fails           = 0;
        reset_n         = 1'b0;
        sdata           = 1'b1;
        rx_if.rx_ready  = 1'b1;
        #12;
        chk("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_if.rx_data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single frame 0xA5
        bit_cyc(1'b1);
        bit_cyc(1'b1);
        frame_body(8'hA5);
        chk("a5_pre_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        bit_cyc(1'b1);
        chk("a5_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("a5_data", {24'd0, rx_if.rx_data}, 32'h0A5);
        bit_cyc(1'b1);
        chk("a5_consumed", {31'd0, rx_if.rx_valid}, 32'd0);

        // Back-to-back 0x3C, 0xC3
        send_frame(8'h3C, 1'b1);
        chk("b2b1_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("b2b1_data", {24'd0, rx_if.rx_data}, 32'h03C);
        send_frame(8'hC3, 1'b1);
        chk("b2b2_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("b2b2_data", {24'd0, rx_if.rx_data}, 32'h0C3);
        chk("b2b_ferr", {31'd0, frame_err}, 32'd0);
        chk("b2b_ovr", {31'd0, overrun}, 32'd0);
        bit_cyc(1'b1);

        // Backpressure: 0x11 held, 0x22 overruns
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        chk("bp1_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("bp1_data", {24'd0, rx_if.rx_data}, 32'h011);
        send_frame(8'h22, 1'b1);
        chk("bp2_ovr", {31'd0, overrun}, 32'd1);
        chk("bp2_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("bp2_data", {24'd0, rx_if.rx_data}, 32'h011);
        bit_cyc(1'b1);
        chk("bp_ovr_pulse", {31'd0, overrun}, 32'd0);
        chk("bp_data_hold", {24'd0, rx_if.rx_data}, 32'h011);
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        sdata = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain", {31'd0, rx_if.rx_valid}, 32'd0);
        rx_if.rx_ready = 1'b0;

        // Drain-and-commit collision
        send_frame(8'h11, 1'b1);
        chk("col1_data", {24'd0, rx_if.rx_data}, 32'h011);
        frame_body(8'h22);
        @(negedge clk);
        sdata = 1'b1;
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("col_ovr", {31'd0, overrun}, 32'd0);
        chk("col_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("col_data", {24'd0, rx_if.rx_data}, 32'h022);
        bit_cyc(1'b1);
        chk("col_drain", {31'd0, rx_if.rx_valid}, 32'd0);

        // Framing error then recovery
        send_frame(8'h5A, 1'b0);
        chk("fe_pulse", {31'd0, frame_err}, 32'd1);
        chk("fe_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        bit_cyc(1'b0);
        chk("fe_one_cycle", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bit_cyc(1'b0);
        end
        bit_cyc(1'b1);
        chk("fe_no_start", {31'd0, rx_if.rx_valid}, 32'd0);
        send_frame(8'h0F, 1'b1);
        chk("fe_rec_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("fe_rec_data", {24'd0, rx_if.rx_data}, 32'h00F);
        chk("fe_rec_ferr", {31'd0, frame_err}, 32'd0);
        bit_cyc(1'b1);

        // Reset mid-frame with a word held
        rx_if.rx_ready = 1'b0;
        send_frame(8'h66, 1'b1);
        chk("mr_held", {24'd0, rx_if.rx_data}, 32'h066);
        bit_cyc(1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_cyc(1'b1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        chk("mr_data", {24'd0, rx_if.rx_data}, 32'd0);
        chk("mr_ferr", {31'd0, frame_err}, 32'd0);
        chk("mr_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        sdata = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rx_if.rx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit_cyc(1'b0);
        end
        chk("mr_arm_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        chk("mr_arm_ferr", {31'd0, frame_err}, 32'd0);
        bit_cyc(1'b1);
        send_frame(8'h81, 1'b1);
        chk("mr_81_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        chk("mr_81_data", {24'd0, rx_if.rx_data}, 32'h081);
        bit_cyc(1'b1);
        chk("mr_81_consumed", {31'd0, rx_if.rx_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
